// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared constants, buffer entry type and squash helper for the register-file write arbiter
package rf_arb_pkg;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA = 5'd31;
  typedef struct packed {
    logic valid;
    logic [4:0] rd;
    logic [31:0] data;
  } rf_arb_entry_t;
  // True when a WB normal write (wb_en/wb_rd) or a jal (r31) this cycle overwrites register rd.
  function automatic logic rd_squash(input logic [4:0] rd, input logic wb_en, input logic [4:0] wb_rd, input logic jal);
    return (wb_en && rd == wb_rd) || (jal && rd == REG_RA);
  endfunction
endpackage

// File: rtl/rf_arb_fifo.sv
// rf_arb_fifo: buffer for MD results that lost arbitration, with squash-by-rd and pending-hit lookup
// Ports: push/push_rd/push_data enqueue at tail; pop drops head; sq_en/sq_rd/sq_jal clear matching
// entries (and a same-cycle push); head_* expose the oldest entry; empty/ready come from the
// registered count; look_rs/look_rt -> hit_rs/hit_rt. With RF_ARB_BYPASS_EN, data_rs/data_rt carry
// the youngest matching entry's data.
module rf_arb_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [4:0]  push_rd,
  input  logic [31:0] push_data,
  input  logic        pop,
  input  logic        sq_en,
  input  logic [4:0]  sq_rd,
  input  logic        sq_jal,
  input  logic [4:0]  look_rs,
  input  logic [4:0]  look_rt,
  output logic        head_valid,
  output logic [4:0]  head_rd,
  output logic [31:0] head_data,
  output logic        empty,
  output logic        ready,
  output logic        hit_rs,
  output logic        hit_rt
`ifdef RF_ARB_BYPASS_EN
  ,
  output logic [31:0] data_rs,
  output logic [31:0] data_rt
`endif
);
  rf_arb_entry_t mem_q [DEPTH];
  rf_arb_entry_t mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  assign head_valid = mem_q[rd_ptr_q].valid;
  assign head_rd = mem_q[rd_ptr_q].rd;
  assign head_data = mem_q[rd_ptr_q].data;
  assign empty = count_q == '0;
  // Registered count only: a full buffer refuses input even while it drains.
  assign ready = count_q < (PTR_W+1)'(DEPTH);
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++)
      if (rd_squash(mem_q[i].rd, sq_en, sq_rd, sq_jal)) mem_d[i].valid = 1'b0;
    // Popped slots are invalidated so the lookup only needs the valid bits.
    if (pop) mem_d[rd_ptr_q].valid = 1'b0;
    if (push) mem_d[wr_ptr_q] = '{valid: !rd_squash(push_rd, sq_en, sq_rd, sq_jal), rd: push_rd, data: push_data};
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end
  // Walk oldest to youngest so the last match is the youngest one.
  always_comb begin
    hit_rs = 1'b0;
    hit_rt = 1'b0;
`ifdef RF_ARB_BYPASS_EN
    data_rs = '0;
    data_rt = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[rd_ptr_q + PTR_W'(i)].valid && mem_q[rd_ptr_q + PTR_W'(i)].rd == look_rs && look_rs != REG_ZERO) begin
        hit_rs = 1'b1;
`ifdef RF_ARB_BYPASS_EN
        data_rs = mem_q[rd_ptr_q + PTR_W'(i)].data;
`endif
      end
      if (mem_q[rd_ptr_q + PTR_W'(i)].valid && mem_q[rd_ptr_q + PTR_W'(i)].rd == look_rt && look_rt != REG_ZERO) begin
        hit_rt = 1'b1;
`ifdef RF_ARB_BYPASS_EN
        data_rt = mem_q[rd_ptr_q + PTR_W'(i)].data;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write ports between WB (priority) and the MD unit
// Ports: wb_valid/wb_rd/wb_data normal WB write; wb_jal/wb_ra_data jal r31 write; md_valid/md_rd/
// md_data/md_ready MD result handshake; dec_rs/dec_rt -> pend_hit_rs/pend_hit_rt buffered-MD hits;
// rf_* registered register-file write controls. Optional macro RF_ARB_BYPASS_EN adds byp_rs_data/
// byp_rt_data carrying the youngest buffered value, turning pend_hit_* into forward-valid flags.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        wb_jal,
  input  logic [31:0] wb_ra_data,
  input  logic        md_valid,
  input  logic [4:0]  md_rd,
  input  logic [31:0] md_data,
  output logic        md_ready,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  output logic        pend_hit_rs,
  output logic        pend_hit_rt,
  output logic        rf_regwrite,
  output logic [4:0]  rf_write_register,
  output logic [31:0] rf_write_data,
  output logic        rf_jal_write,
  output logic [31:0] rf_jal_ra_data
`ifdef RF_ARB_BYPASS_EN
  ,
  output logic [31:0] byp_rs_data,
  output logic [31:0] byp_rt_data
`endif
);
  logic        regwrite_q, regwrite_d;
  logic [4:0]  write_register_q, write_register_d;
  logic [31:0] write_data_q, write_data_d;
  logic        jal_write_q, jal_write_d;
  logic [31:0] jal_ra_data_q, jal_ra_data_d;
  logic        head_valid, empty, fifo_ready;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        wb_norm, md_acc, md_wt, md_push, fifo_pop, head_live;
  rf_arb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(md_push),
    .push_rd(md_rd),
    .push_data(md_data),
    .pop(fifo_pop),
    .sq_en(wb_norm),
    .sq_rd(wb_rd),
    .sq_jal(wb_jal),
    .look_rs(dec_rs),
    .look_rt(dec_rt),
    .head_valid(head_valid),
    .head_rd(head_rd),
    .head_data(head_data),
    .empty(empty),
    .ready(fifo_ready),
    .hit_rs(pend_hit_rs),
    .hit_rt(pend_hit_rt)
`ifdef RF_ARB_BYPASS_EN
    ,
    .data_rs(byp_rs_data),
    .data_rt(byp_rt_data)
`endif
  );
  assign md_ready = fifo_ready;
  assign wb_norm = wb_valid && wb_rd != REG_ZERO;
  // r0 results are handshaken but never buffered or written.
  assign md_acc = md_valid && fifo_ready && md_rd != REG_ZERO;
  // A jal in the same cycle wins over an r31 write inside the register file, so r31 cannot pass.
  assign md_wt = !wb_norm && empty && md_acc && !(wb_jal && md_rd == REG_RA);
  assign md_push = md_acc && !md_wt;
  // A non-empty buffer always consumes the free slot; a dead head is popped without a write.
  assign fifo_pop = !wb_norm && !empty;
  assign head_live = head_valid && !(wb_jal && head_rd == REG_RA);
  always_comb begin
    regwrite_d = wb_norm || (fifo_pop && head_live) || md_wt;
    write_register_d = wb_norm ? wb_rd : (fifo_pop && head_live) ? head_rd : md_wt ? md_rd : '0;
    write_data_d = wb_norm ? wb_data : (fifo_pop && head_live) ? head_data : md_wt ? md_data : '0;
    jal_write_d = wb_jal;
    jal_ra_data_d = wb_jal ? wb_ra_data : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      write_register_q <= '0;
      write_data_q <= '0;
      jal_write_q <= 1'b0;
      jal_ra_data_q <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      write_register_q <= write_register_d;
      write_data_q <= write_data_d;
      jal_write_q <= jal_write_d;
      jal_ra_data_q <= jal_ra_data_d;
    end
  end
  assign rf_regwrite = regwrite_q;
  assign rf_write_register = write_register_q;
  assign rf_write_data = write_data_q;
  assign rf_jal_write = jal_write_q;
  assign rf_jal_ra_data = jal_ra_data_q;
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's two write paths between two writers:
  - the WB stage (normal writes and jal return-address writes);
  - the long-latency multiply/divide unit (MD), which returns results out of pipeline order.
- WB always has priority and never stalls.
- MD results that lose arbitration are held in a small FIFO and drained into idle write slots.
- Decode gets pending-hit flags so it can stall on registers whose MD result is still buffered.

Parameters:
- DEPTH, 4, number of MD result buffer entries (power of two, 2..16).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- wb_valid  in  1  WB stage issues a normal write this cycle
- wb_rd  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_jal  in  1  WB stage issues a jal write of r31 this cycle
- wb_ra_data  in  32  jal return address
- md_valid  in  1  MD result offered
- md_rd  in  5  MD destination register
- md_data  in  32  MD result
- md_ready  out  1  MD result accepted when md_valid && md_ready
- dec_rs  in  5  decode source register 1
- dec_rt  in  5  decode source register 2
- pend_hit_rs  out  1  dec_rs has a buffered MD write outstanding
- pend_hit_rt  out  1  dec_rt has a buffered MD write outstanding
- rf_regwrite  out  1  to register file RegWrite
- rf_write_register  out  5  to register file Write_register
- rf_write_data  out  32  to register file Write_data
- rf_jal_write  out  1  to register file Jal_write
- rf_jal_ra_data  out  32  to register file Jal_ra_data

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset clears everything:
  - all rf_* outputs go to 0;
  - the FIFO is empty and every entry's valid bit is cleared;
  - md_ready=1 and pend_hit_*=0 after reset.
  - An MD handshake in the reset cycle is discarded.
- All rf_* outputs are registered. A write selected in cycle N is presented in cycle N+1, and the register file commits it on the edge ending N+1.
- Normal-port selection in cycle N, in priority order:
  - wb_valid with wb_rd!=0;
  - the FIFO head, if its entry is valid;
  - the incoming MD result, only when the FIFO is empty (write-through);
  - otherwise rf_regwrite=0 next cycle.
- wb_jal drives the jal path (rf_jal_write, rf_jal_ra_data). It is independent of the normal port, so a jal and a normal write may issue in the same cycle.
- Conflict rule: an MD write with rd==31 may not use the normal port in a cycle where wb_jal=1, because jal wins inside the register file. It stays or is enqueued instead.
- Writes to r0, from either source, are dropped: never enqueued, never emitted. An MD write to r0 is still handshaken (md_ready honoured).
- Accepted MD results that are not written through are enqueued at the tail in arrival order.
- md_ready = (count < DEPTH). It is computed from the registered count only, so a full FIFO refuses input even in a cycle where it also drains.
- WAW squash: when WB issues a write (normal to wb_rd, or jal to r31), every buffered entry with a matching rd has its valid bit cleared in the same cycle. This also applies to an MD result being enqueued that cycle with a matching rd.
- A squashed head is popped without a write. It consumes the cycle, and no second head is examined.
- Pointers wrap modulo DEPTH; count is PTR_W+1 bits. Simultaneous push and pop leaves count unchanged.
- pend_hit_rs is combinational: dec_rs!=0 and some valid FIFO entry has rd==dec_rs. pend_hit_rt is the same for dec_rt.
- The output stage is not included in the hit check; the existing WB forwarding covers it.

Optional Feature:
- Macro: RF_ARB_BYPASS_EN.
- Defined:
  - adds outputs byp_rs_data[31:0] and byp_rt_data[31:0];
  - pend_hit_* then means "forward data valid" rather than "stall";
  - the data is from the youngest valid matching FIFO entry.
- Undefined: ports absent; pend_hit_* used for stall only.

Decomposition:
- Package rf_arb_pkg holds:
  - the REG_ZERO and REG_RA constants (0, 31);
  - the typedef for a buffer entry {valid, rd[4:0], data[31:0]}.
- One natural sub-module: rf_arb_fifo, holding the storage, pointers and count, squash-by-rd, and match lookup.
- Arbitration and the output registers stay in the top module.

Test Plan:
- Reset then idle:
  - all rf_*=0;
  - md_ready=1;
  - pend_hit_rs=0 with dec_rs=5.
- MD write-through: md rd=8, data=0x1234 with WB idle -> cycle+1: rf_regwrite=1, rf_write_register=8, rf_write_data=0x1234.
- Collision and drain:
  - WB rd=3 and MD rd=9 in the same cycle -> WB is emitted first;
  - pend_hit_rs=1 for dec_rs=9 until the drain;
  - r9 is written one cycle later.
- Full FIFO:
  - hold wb_valid for 6 cycles while offering 5 MD results;
  - md_ready drops after 4 accepts;
  - the 5th is accepted after the first drain;
  - write order is preserved.
- WAW squash:
  - buffer MD rd=10, then WB writes rd=10 value 0xAA;
  - the entry is squashed and no later write to r10 occurs, so final r10=0xAA.
- Jal conflict: wb_jal=1 and MD rd=31 in the same cycle -> only rf_jal_write is asserted; the MD entry is enqueued and then squashed by the jal.
